demux_stream_1xn: RTL and testbench

DEMUX_STREAM_1XN -- requirements
Module: demux_stream_1xn

---
 rtl/demux_stream_1xn_if.sv | 29 ++
 rtl/demux_stream_1xn.sv | 122 ++++++++++++
 tb/tb_demux_stream_1xn.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_1xn_if.sv
// Stream bundle for the 1-to-N packet demultiplexer: one input stream and
// N per-channel output streams sharing a single clock.
interface demux_stream_1xn_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     in_last;
    logic [SEL_W-1:0]         in_sel;
    logic [N_CH-1:0]          out_valid;
    logic [N_CH-1:0]          out_ready;
    logic [N_CH*DATA_W-1:0]   out_data;
    logic [N_CH-1:0]          out_last;

    // Traffic source and sinks (drives the input, accepts the outputs).
    modport master (
        output in_valid, in_data, in_last, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // The demultiplexer itself.
    modport slave (
        input  in_valid, in_data, in_last, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/demux_stream_1xn.sv
// Packet-aware 1-to-N stream demultiplexer: the channel is chosen on the first
// beat and held until the last beat; out-of-range channels swallow the packet.
module demux_stream_1xn #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    demux_stream_1xn_if.slave   bus,
    output logic [15:0]         drop_cnt
);

    localparam int N_SEL = 1 << SEL_W;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_reg;
    logic [SEL_W-1:0]   lock_sel_reg;
    logic [15:0]        drop_cnt_reg;

    logic [SEL_W-1:0]   eff_sel;
    logic [N_SEL-1:0]   sel_free;
    logic [N_SEL-1:0]   sel_in_range;
    logic               in_range;
    logic               accept;
    logic               drop;

    logic [N_CH-1:0]    valid_vec;
    logic [N_CH-1:0]    last_vec;
    logic [N_CH-1:0]    load;

    // Once a packet is open the captured channel wins over whatever in_sel does.
    assign eff_sel = (state_reg == LOCKED) ? lock_sel_reg : bus.in_sel;

    // Lookup tables spanning the whole select space so that indexing with
    // eff_sel never leaves the vector; unused codes are always "free" drops.
    generate
        for (genvar gi = 0; gi < N_SEL; gi++) begin : g_sel
            if (gi < N_CH) begin : g_real
                assign sel_free[gi]     = !valid_vec[gi] | bus.out_ready[gi];
                assign sel_in_range[gi] = 1'b1;
            end else begin : g_void
                assign sel_free[gi]     = 1'b1;
                assign sel_in_range[gi] = 1'b0;
            end
        end
    endgenerate

    assign in_range     = sel_in_range[eff_sel];
    assign bus.in_ready = sel_free[eff_sel];
    assign accept       = bus.in_valid & bus.in_ready;
    assign drop         = accept & !in_range;

    // Packet framing FSM and discard counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            lock_sel_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (accept) begin
                case (state_reg)
                    IDLE: begin
                        if (!bus.in_last) begin
                            state_reg    <= LOCKED;
                            lock_sel_reg <= bus.in_sel;
                        end
                    end
                    LOCKED: begin
                        if (bus.in_last) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
            if (drop && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign drop_cnt = drop_cnt_reg;

    // One-entry output register per channel; load takes priority over drain
    // so a beat arriving on the drain edge replaces the old one without a bubble.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic              valid_reg;
            logic              last_reg;
            logic [DATA_W-1:0] data_reg;

            assign load[gi] = accept & in_range & (eff_sel == SEL_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    data_reg  <= '0;
                end else if (load[gi]) begin
                    valid_reg <= 1'b1;
                    last_reg  <= bus.in_last;
                    data_reg  <= bus.in_data;
                end else if (valid_reg && bus.out_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign valid_vec[gi]                        = valid_reg;
            assign last_vec[gi]                         = last_reg;
            assign bus.out_data[gi*DATA_W +: DATA_W]    = data_reg;
        end
    endgenerate

    assign bus.out_valid = valid_vec;
    assign bus.out_last  = last_vec;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed bench for demux_stream_1xn: a per-cycle packet/queue model of the
// default 8-channel instance plus literal checks on both 8- and 6-channel builds.
module tb_demux_stream_1xn;

    localparam int NC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt6;

    always #5 clk = ~clk;

    demux_stream_1xn_if #(.DATA_W(8), .N_CH(8), .SEL_W(3)) bus  ();
    demux_stream_1xn_if #(.DATA_W(8), .N_CH(6), .SEL_W(3)) bus6 ();

    demux_stream_1xn #(.DATA_W(8), .N_CH(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus), .drop_cnt(drop_cnt)
    );

    demux_stream_1xn #(.DATA_W(8), .N_CH(6), .SEL_W(3)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6), .drop_cnt(drop_cnt6)
    );

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: is a packet open, which channel it owns, and what
    // beat (if any) is parked in each channel's single slot.
    bit         m_valid [NC];
    logic [7:0] m_data  [NC];
    bit         m_last  [NC];
    bit         m_open;
    int         m_ch;
    int         m_drop;

    task automatic m_reset();
        for (int k = 0; k < NC; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 8'h00;
            m_last[k]  = 1'b0;
        end
        m_open = 1'b0;
        m_ch   = 0;
        m_drop = 0;
    endtask

    initial begin
        logic [7:0]  e_valid;
        logic [7:0]  e_last;
        logic [63:0] e_data;
        int          eff;
        bit          rdy;
        bit          acc;
        m_reset();
        forever begin
            @(negedge clk);
            #2;
            if (rst) m_reset();
            eff = m_open ? m_ch : int'(bus.in_sel);
            rdy = (eff >= NC) ? 1'b1 : (!m_valid[eff] || bus.out_ready[eff]);
            for (int k = 0; k < NC; k++) begin
                e_valid[k]         = m_valid[k];
                e_last[k]          = m_last[k];
                e_data[k*8 +: 8]   = m_data[k];
            end
            if (mon_en) begin
                chk("mdl_out_valid", bus.out_valid, e_valid);
                chk("mdl_out_data",  bus.out_data,  e_data);
                chk("mdl_out_last",  bus.out_last,  e_last);
                chk("mdl_in_ready",  bus.in_ready,  rdy);
                chk("mdl_drop_cnt",  drop_cnt,      m_drop);
            end
            if (!rst) begin
                acc = bus.in_valid && rdy;
                for (int k = 0; k < NC; k++) begin
                    if (m_valid[k] && bus.out_ready[k]) m_valid[k] = 1'b0;
                    if (acc && k == eff) begin
                        m_valid[k] = 1'b1;
                        m_data[k]  = bus.in_data;
                        m_last[k]  = bus.in_last;
                    end
                end
                if (acc) begin
                    if (eff >= NC && m_drop < 65535) m_drop++;
                    if (!m_open && !bus.in_last) begin
                        m_open = 1'b1;
                        m_ch   = int'(bus.in_sel);
                    end else if (m_open && bus.in_last) begin
                        m_open = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive(input int sel, input logic [7:0] d, input bit last);
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'(sel);
        bus.in_data  = d;
        bus.in_last  = last;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drive6(input int sel, input logic [7:0] d, input bit last);
        bus6.in_valid = 1'b1;
        bus6.in_sel   = 3'(sel);
        bus6.in_data  = d;
        bus6.in_last  = last;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.in_last    = 1'b0;
        bus.in_sel     = 3'd0;
        bus.out_ready  = 8'hFF;
        bus6.in_valid  = 1'b0;
        bus6.in_data   = 8'h00;
        bus6.in_last   = 1'b0;
        bus6.in_sel    = 3'd0;
        bus6.out_ready = 6'h3F;
        #1 rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #3;
        chk("rst_out_valid", bus.out_valid, 8'h00);
        chk("rst_out_data",  bus.out_data,  64'h0);
        chk("rst_out_last",  bus.out_last,  8'h00);
        chk("rst_drop_cnt",  drop_cnt,      16'h0000);
        chk("rst_drop_cnt6", drop_cnt6,     16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Single beat to channel 5
        @(negedge clk); drive(5, 8'hA5, 1'b1);
        @(negedge clk); idle(); #3;
        chk("single_valid", bus.out_valid, 8'h20);
        chk("single_data5", bus.out_data[47:40], 8'hA5);
        chk("single_last5", bus.out_last[5], 1'b1);
        @(negedge clk); #3;
        chk("single_clear", bus.out_valid, 8'h00);
        chk("single_hold",  bus.out_data[47:40], 8'hA5);

        // Locked 3-beat packet to channel 2 while in_sel moves to 6
        @(negedge clk); drive(2, 8'h11, 1'b0);
        @(negedge clk); drive(6, 8'h22, 1'b0); #3;
        chk("pkt_b0_valid", bus.out_valid, 8'h04);
        chk("pkt_b0_data",  bus.out_data[23:16], 8'h11);
        @(negedge clk); drive(6, 8'h33, 1'b1); #3;
        chk("pkt_b1_valid", bus.out_valid, 8'h04);
        chk("pkt_b1_data",  bus.out_data[23:16], 8'h22);
        @(negedge clk); idle(); #3;
        chk("pkt_b2_valid", bus.out_valid, 8'h04);
        chk("pkt_b2_data",  bus.out_data[23:16], 8'h33);
        chk("pkt_b2_last",  bus.out_last[2], 1'b1);
        @(negedge clk); #3;
        chk("pkt_done", bus.out_valid, 8'h00);
        @(negedge clk); drive(6, 8'h66, 1'b1);
        @(negedge clk); idle(); #3;
        chk("pkt_after_valid", bus.out_valid, 8'h40);
        chk("pkt_after_data",  bus.out_data[55:48], 8'h66);

        // Backpressure on channel 1, channel 3 flowing
        @(negedge clk); bus.out_ready = 8'hFD; drive(1, 8'hA1, 1'b1); #3;
        chk("bp_rdy_a", bus.in_ready, 1'b1);
        @(negedge clk); drive(3, 8'hC3, 1'b1); #3;
        chk("bp_rdy_c",   bus.in_ready, 1'b1);
        chk("bp_hold_a",  bus.out_valid, 8'h02);
        @(negedge clk); drive(1, 8'hB1, 1'b1); #3;
        chk("bp_rdy_b",   bus.in_ready, 1'b0);
        chk("bp_both",    bus.out_valid, 8'h0A);
        chk("bp_data_a",  bus.out_data[15:8], 8'hA1);
        @(negedge clk); #3;
        chk("bp_rdy_b2",  bus.in_ready, 1'b0);
        chk("bp_ch3_gone", bus.out_valid, 8'h02);
        @(negedge clk); bus.out_ready = 8'hFF; #3;
        chk("bp_rdy_rel", bus.in_ready, 1'b1);
        @(negedge clk); idle(); #3;
        chk("bp_b_valid", bus.out_valid, 8'h02);
        chk("bp_b_data",  bus.out_data[15:8], 8'hB1);
        @(negedge clk); #3;
        chk("bp_clear",   bus.out_valid, 8'h00);

        // Out-of-range drops on the 6-channel build
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive6(7, 8'(i), (i == 3)); #3;
            chk("drop_rdy",   bus6.in_ready,  1'b1);
            chk("drop_novld", bus6.out_valid, 6'h00);
        end
        @(negedge clk); bus6.in_valid = 1'b0; #3;
        chk("drop_cnt4",  drop_cnt6,      16'd4);
        chk("drop_novld", bus6.out_valid, 6'h00);
        @(negedge clk); drive6(5, 8'h55, 1'b1);
        @(negedge clk); bus6.in_valid = 1'b0; #3;
        chk("n6_ch5_valid", bus6.out_valid, 6'h20);
        chk("n6_ch5_data",  bus6.out_data[47:40], 8'h55);
        chk("n6_cnt_keep",  drop_cnt6, 16'd4);

        mon_en = 1'b0;
        @(negedge clk); drive6(7, 8'hEE, 1'b1);
        repeat (65530) @(negedge clk);
        bus6.in_valid = 1'b0; #3;
        chk("drop_fffe", drop_cnt6, 16'hFFFE);
        @(negedge clk); drive6(7, 8'hEF, 1'b1);
        repeat (3) @(negedge clk);
        bus6.in_valid = 1'b0; #3;
        chk("drop_sat", drop_cnt6, 16'hFFFF);
        mon_en = 1'b1;

        // Reset in the middle of a packet locked to channel 4
        @(negedge clk); drive(4, 8'h40, 1'b0);
        @(negedge clk); drive(2, 8'h41, 1'b0); #3;
        chk("mid_valid", bus.out_valid, 8'h10);
        @(negedge clk); idle(); rst = 1'b1; #3;
        chk("mid_rst_valid", bus.out_valid, 8'h00);
        chk("mid_rst_data",  bus.out_data,  64'h0);
        chk("mid_rst_drop6", drop_cnt6,     16'h0000);
        chk("mid_rst_rdy",   bus.in_ready,  1'b1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); drive(0, 8'h77, 1'b1);
        @(negedge clk); idle(); #3;
        chk("post_rst_valid", bus.out_valid, 8'h01);
        chk("post_rst_data",  bus.out_data[7:0], 8'h77);
        @(negedge clk); #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
